// File: rtl/packet_rx_parser.sv
// packet_rx_parser: UART byte stream to validated 16-bit word packets with XOR checksum, timeout and overrun reporting
module packet_rx_parser #(
  parameter logic [7:0] FRAME_HDR    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic        pkt_valid,
  output logic        pkt_pending,
  output logic [3:0]  pkt_opcode,
  output logic [3:0]  pkt_word_cnt,
  input  logic        pkt_ack,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        pkt_err,
  output logic [1:0]  err_code
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  typedef enum logic [2:0] {IDLE, CNT, DATA_HI, DATA_LO, CSUM, HOLD} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [7:0] r_xor, r_hi;
  logic [3:0] r_cnt, r_op, r_idx, w_idx_n;
  logic [15:0] r_mem [16];
  logic w_counting, w_timeout, w_valid, w_err, w_wr, w_hdr;
  logic [1:0] w_code;
  assign w_idx_n = r_idx + 4'd1;
  assign w_hdr = new_rx_data && rx_data == FRAME_HDR;
  assign w_counting = r_state inside {CNT, DATA_HI, DATA_LO, CSUM};
  assign w_timeout = w_counting && !new_rx_data && r_timer == TW'(TIMEOUT_CLKS - 1);
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_timeout) w_next = IDLE;
    else case (r_state)
      IDLE:    w_next = w_hdr ? CNT : IDLE;
      CNT:     if (new_rx_data) w_next = rx_data[7:4] != 4'd0 ? DATA_HI : CSUM;
      DATA_HI: if (new_rx_data) w_next = DATA_LO;
      DATA_LO: if (new_rx_data) w_next = w_idx_n == r_cnt ? CSUM : DATA_HI;
      CSUM:    if (new_rx_data) w_next = rx_data == r_xor ? HOLD : IDLE;
      HOLD:    if (pkt_ack) w_next = w_hdr ? CNT : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_valid = r_state == CSUM && new_rx_data && rx_data == r_xor;
    w_err = w_timeout || (new_rx_data && ((r_state == CSUM && rx_data != r_xor) || (r_state == HOLD && !pkt_ack)));
    w_code = w_timeout ? 2'b10 : r_state == HOLD ? 2'b11 : 2'b01;
    w_wr = r_state == DATA_LO && new_rx_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_xor <= '0;
      r_hi <= '0;
      r_cnt <= '0;
      r_op <= '0;
      r_idx <= '0;
      pkt_valid <= 1'b0;
      pkt_pending <= 1'b0;
      pkt_err <= 1'b0;
      err_code <= 2'b00;
      pkt_opcode <= '0;
      pkt_word_cnt <= '0;
      rd_data <= '0;
    end else begin
      r_timer <= (new_rx_data || !w_counting || w_timeout) ? '0 : r_timer + 1'b1;
      pkt_valid <= w_valid;
      pkt_pending <= w_next == HOLD;
      pkt_err <= w_err;
      if (w_err) err_code <= w_code;
      if (w_valid) {pkt_word_cnt, pkt_opcode} <= {r_cnt, r_op};
      rd_data <= r_mem[rd_addr];
      if (new_rx_data && r_state == CNT) begin
        {r_cnt, r_op} <= rx_data;
        r_xor <= rx_data;
        r_idx <= '0;
      end
      if (new_rx_data && (r_state == DATA_HI || r_state == DATA_LO)) r_xor <= r_xor ^ rx_data;
      if (new_rx_data && r_state == DATA_HI) r_hi <= rx_data;
      if (w_wr) r_idx <= w_idx_n;
    end
  end
  // buffer is deliberately not reset; only the index steers writes
  always_ff @(posedge clk) if (w_wr && !rst) r_mem[r_idx] <= {r_hi, rx_data};
endmodule

// File: doc/packet_rx_parser.md
# packet_rx_parser

Byte-level packet parser between the FPGA UART receiver and the navigation core. It hunts for frame header 0xA5, decodes the word-count/opcode byte, and assembles the 16-bit data words into an internal buffer. It verifies the trailing XOR checksum, then presents a validated packet to the core until the core acknowledges it. Malformed, stalled and overrunning packets are reported as errors.

## Interface
- FRAME_HDR, 8'hA5, header byte that starts a packet
- TIMEOUT_CLKS, 50000, maximum clk cycles allowed between consecutive bytes inside a packet (about 11 byte times at 115200 baud and 50 MHz)
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from the UART receiver; valid only while new_rx_data=1
- new_rx_data  in  1  one-cycle strobe, one per received byte
- pkt_valid  out  1  one-cycle pulse: a complete packet passed its checksum
- pkt_pending  out  1  high from pkt_valid until pkt_ack; buffer and fields are stable while high
- pkt_opcode  out  4  opcode of the held packet
- pkt_word_cnt  out  4  number of data words in the held packet (0–15)
- pkt_ack  in  1  consumer releases the held packet
- rd_addr  in  4  word buffer read address
- rd_data  out  16  buffer word at rd_addr; registered, 1-cycle latency
- pkt_err  out  1  one-cycle error pulse
- err_code  out  2  01 = checksum, 10 = timeout, 11 = overrun; holds its last value

## Operation
- Packet format: FRAME_HDR, then CNT byte ({word_cnt[7:4], opcode[3:0]}), then 2×word_cnt data bytes with each word MSB first, then CSUM.
- CSUM is the 8-bit XOR of the CNT byte and all data bytes. FRAME_HDR is excluded.
- States and transitions:
  - IDLE: a byte equal to FRAME_HDR moves to CNT. Any other byte is dropped silently with no error.
  - CNT: latch word_cnt and opcode, seed the XOR with this byte, clear the word index. Go to DATA_HI if word_cnt>0, otherwise CSUM.
  - DATA_HI: latch the high byte into a staging register, update XOR, go to DATA_LO.
  - DATA_LO: write {hi, byte} to buffer[index], increment index, update XOR. Go to CSUM when index reaches word_cnt, otherwise DATA_HI.
  - CSUM: on a match, pulse pkt_valid, set pkt_pending, and go to HOLD. On a mismatch, pulse pkt_err with err_code=01 and go to IDLE.
  - HOLD: a byte arriving without pkt_ack is dropped, pulses pkt_err with err_code=11, and the state stays HOLD. pkt_ack clears pkt_pending and goes to IDLE.
- A byte arriving in the same cycle as pkt_ack is evaluated as an IDLE byte, so a simultaneous 0xA5 goes straight to CNT.
- pkt_ack outside HOLD is ignored.
- Inter-byte timer:
  - Width is $clog2(TIMEOUT_CLKS+1).
  - Cleared by every new_rx_data. Counts only in CNT, DATA_HI, DATA_LO and CSUM.
  - On reaching TIMEOUT_CLKS: pulse pkt_err with err_code=10 and go to IDLE. The partial packet is discarded and pkt_opcode/pkt_word_cnt are unchanged.
- pkt_opcode and pkt_word_cnt update only when pkt_valid fires, so values from an in-progress packet never appear at the outputs.
- Buffer: 16×16 bits, single write port and single read port. Buffer writes happen during a packet. A packet in flight can overwrite words of the previous packet only after that packet has been acked.

## Timing
- Reset values: pkt_valid=0, pkt_pending=0, pkt_err=0, err_code=00, pkt_opcode=0, pkt_word_cnt=0, rd_data=0, state=IDLE, timer=0. Buffer contents are not cleared.
- Reset during a packet returns to IDLE on the next edge with no error pulse.
- pkt_valid and pkt_pending rise on the edge after the cycle in which CSUM is strobed, i.e. 1-cycle latency.
- pkt_err has the same 1-cycle latency relative to the offending byte or timer expiry.
- pkt_pending falls on the edge after the pkt_ack cycle.
- rd_data reflects rd_addr sampled on the previous edge. rd_addr ≥ word_cnt returns stale buffer contents.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Good packet: A5 21 12 34 AB CD 61 → one pkt_valid pulse, opcode=1, word_cnt=2, buffer[0]=16'h1234, buffer[1]=16'hABCD, pkt_pending=1 until ack.
- Zero-word packet: A5 03 03 → pkt_valid, opcode=3, word_cnt=0. Leading garbage 00 FF 5A before it → still exactly one pkt_valid and no pkt_err.
- Bad checksum: A5 21 12 34 AB CD 62 → pkt_err with err_code=01, no pkt_valid, outputs unchanged. A following good packet is accepted.
- Timeout: A5 21 12 then idle for TIMEOUT_CLKS cycles (set to 100 in the bench) → pkt_err with err_code=10 exactly 100 cycles after the 12 strobe. A following good packet is accepted.
- Overrun: good packet, no ack, then A5 sent → pkt_err with err_code=11 and buffer unchanged. Then ack together with a new A5 strobe in the same cycle → that packet parses to pkt_valid.
- Reset mid-packet: assert rst after A5 21 12 → all outputs return to reset values. The remaining bytes 34 AB CD 61 are dropped in IDLE with no pkt_valid and no pkt_err.
